led_pwm_fader: RTL and testbench

- Downstream stage of the LED pattern sequencer. Consumes its 3-bit RGB on/off pattern and drives the physical RGB LED pins.
- Each channel is driven by a PWM generator. The duty cycle ramps linearly toward the requested brightness, so pattern changes fade rather than snap.
- All inputs are synchronous to CLK; no input synchronisers.

---
 rtl/led_pwm_fader.sv | 78 +++++++
 tb/tb_led_pwm_fader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : led_pwm_fader
// Brief    : Three-channel RGB PWM driver whose duty ramps one step at a time
//            toward LED_IN ? BRIGHT : 0. Optional LED_PWM_FADER_ACTIVE_LOW_EN
//            inverts LED_OUT for common-anode LEDs.
// Revision : 1.0 - initial release
// ============================================================================
module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int FADE_DIV = 16
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [2:0]          LED_IN,
    input  logic [PWM_BITS-1:0] BRIGHT,
    output logic [2:0]          LED_OUT,
    output logic                FADE_BUSY
);

    localparam int                 c_PRE_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(FADE_DIV - 1);
`ifdef LED_PWM_FADER_ACTIVE_LOW_EN
    localparam logic [2:0]         c_OUT_INV  = 3'b111;
`else
    localparam logic [2:0]         c_OUT_INV  = 3'b000;
`endif

    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [c_PRE_W-1:0]  r_presc;
    logic [2:0]          w_differs;
    logic [2:0]          w_pwm_on;
    logic                w_period_end;
    logic                w_step;

    assign w_period_end = (r_pwm_cnt == {PWM_BITS{1'b1}});
    assign w_step       = w_period_end && (r_presc == c_PRE_LAST);

    // Duty only moves at a period end, so a PWM period never sees two duties.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [PWM_BITS-1:0] w_target;
        logic [PWM_BITS-1:0] r_duty;

        assign w_target      = LED_IN[gi] ? BRIGHT : '0;
        assign w_differs[gi] = (r_duty != w_target);
        assign w_pwm_on[gi]  = (r_pwm_cnt < r_duty);

        always_ff @(posedge CLK) begin
            if (RST) begin
                r_duty <= '0;
            end else if (w_step) begin
                if (r_duty < w_target) begin
                    r_duty <= r_duty + PWM_BITS'(1);
                end else if (r_duty > w_target) begin
                    r_duty <= r_duty - PWM_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pwm_cnt <= '0;
            r_presc   <= '0;
            LED_OUT   <= c_OUT_INV;
            FADE_BUSY <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            if (w_period_end) begin
                r_presc <= (r_presc == c_PRE_LAST) ? '0 : r_presc + c_PRE_W'(1);
            end
            LED_OUT   <= w_pwm_on ^ c_OUT_INV;
            FADE_BUSY <= |w_differs;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pwm_fader
// Brief    : Scoreboard bench for led_pwm_fader (PWM_BITS=4, FADE_DIV=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pwm_fader;

    localparam int c_PWM_BITS = 4;
    localparam int c_FADE_DIV = 2;
`ifdef LED_PWM_FADER_ACTIVE_LOW_EN
    localparam logic [2:0] c_INV = 3'b111;
`else
    localparam logic [2:0] c_INV = 3'b000;
`endif

    logic                  CLK;
    logic                  RST;
    logic [2:0]            LED_IN;
    logic [c_PWM_BITS-1:0] BRIGHT;
    logic [2:0]            LED_OUT;
    logic                  FADE_BUSY;

    led_pwm_fader #(.PWM_BITS(c_PWM_BITS), .FADE_DIV(c_FADE_DIV)) u_dut (
        .CLK       (CLK),
        .RST       (RST),
        .LED_IN    (LED_IN),
        .BRIGHT    (BRIGHT),
        .LED_OUT   (LED_OUT),
        .FADE_BUSY (FADE_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Expected LED values are in active-high (logical) terms.
    typedef struct {
        string      name;
        int         due;
        bit         is_cnt;
        logic [2:0] led;
        logic       busy;
        int         c2, c1, c0;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push_i(input string nm, input int due, input logic [2:0] led, input logic busy);
        exp_t e;
        e.name = nm; e.due = due; e.is_cnt = 1'b0; e.led = led; e.busy = busy;
        e.c2 = 0; e.c1 = 0; e.c0 = 0;
        q.push_back(e);
    endtask

    task automatic push_c(input string nm, input int due, input int c2, input int c1, input int c0);
        exp_t e;
        e.name = nm; e.due = due; e.is_cnt = 1'b1; e.led = 3'b000; e.busy = 1'b0;
        e.c2 = c2; e.c1 = c1; e.c0 = c0;
        q.push_back(e);
    endtask

    // Monitor: keeps the last 16 logical LED samples and retires due entries.
    initial begin : p_monitor
        logic [2:0] hist [16];
        exp_t       e;
        int         k2, k1, k0;
        for (int i = 0; i < 16; i++) hist[i] = 3'b000;
        forever begin
            @(negedge CLK);
            for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = LED_OUT ^ c_INV;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_cmp++;
                if (e.due < cyc) begin
                    n_bad++;
                    $display("FAIL %s: sample missed (due %0d, now %0d)", e.name, e.due, cyc);
                end else if (e.is_cnt) begin
                    k2 = 0; k1 = 0; k0 = 0;
                    for (int i = 0; i < 16; i++) begin
                        k2 += int'(hist[i][2]);
                        k1 += int'(hist[i][1]);
                        k0 += int'(hist[i][0]);
                    end
                    if (k2 != e.c2 || k1 != e.c1 || k0 != e.c0) begin
                        n_bad++;
                        $display("FAIL %s: on-cycles/16 got R=%0d G=%0d B=%0d want R=%0d G=%0d B=%0d",
                                 e.name, k2, k1, k0, e.c2, e.c1, e.c0);
                    end
                end else if ((LED_OUT ^ c_INV) != e.led || FADE_BUSY !== e.busy) begin
                    n_bad++;
                    $display("FAIL %s: LED_OUT=%b FADE_BUSY=%b want LED_OUT=%b FADE_BUSY=%b",
                             e.name, LED_OUT, FADE_BUSY, e.led ^ c_INV, e.busy);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge CLK);
    endtask

    // Called at a negedge; returns the cycle of the last reset edge (pwm_cnt=0).
    task automatic reset_and_start(input int n, input logic [2:0] led,
                                   input logic [c_PWM_BITS-1:0] br, output int b);
        RST = 1'b1;
        repeat (n) @(negedge CLK);
        RST    = 1'b0;
        LED_IN = led;
        BRIGHT = br;
        b      = cyc;
    endtask

    initial begin : p_stim
        int b;
        int b2;
        RST = 1'b1; LED_IN = 3'b000; BRIGHT = 4'd15;

        // Reset and idle
        push_i("rst_c1", 1, 3'b000, 1'b0);
        push_i("rst_c2", 2, 3'b000, 1'b0);
        push_i("rst_c3", 3, 3'b000, 1'b0);
        reset_and_start(3, 3'b000, 4'd15, b);
        push_i("idle_a", b + 1, 3'b000, 1'b0);
        push_i("idle_b", b + 20, 3'b000, 1'b0);
        push_i("idle_c", b + 40, 3'b000, 1'b0);
        push_c("idle_cnt", b + 48, 0, 0, 0);
        wait_until(b + 60);

        // Fade up on red; steps land at b+32*j
        reset_and_start(1, 3'b100, 4'd15, b);
        push_i("up_busy", b + 1, 3'b000, 1'b1);
        push_c("up_d1", b + 48, 1, 0, 0);
        push_c("up_d7", b + 240, 7, 0, 0);
        push_i("up_last_busy", b + 480, 3'b000, 1'b1);
        push_i("up_settled", b + 481, 3'b100, 1'b0);
        push_c("up_d15", b + 496, 15, 0, 0);
        push_i("up_gap", b + 512, 3'b000, 1'b0);
        push_c("up_d15b", b + 560, 15, 0, 0);
        wait_until(b + 570);

        // Fade down, then back up, then reverse at duty 7
        LED_IN = 3'b000;
        push_i("dn_busy", b + 571, 3'b100, 1'b1);
        push_c("dn_d8", b + 784, 8, 0, 0);
        push_i("dn_zero", b + 1025, 3'b000, 1'b0);
        push_c("dn_d0", b + 1056, 0, 0, 0);
        wait_until(b + 1060);
        LED_IN = 3'b100;
        push_c("re_pk15", b + 1552, 15, 0, 0);
        wait_until(b + 1540);
        LED_IN = 3'b000;
        wait_until(b + 1800);
        LED_IN = 3'b100;
        push_c("rev_d7", b + 1808, 7, 0, 0);
        push_c("rev_d8", b + 1840, 8, 0, 0);
        push_c("rev_d9", b + 1872, 9, 0, 0);
        wait_until(b + 1880);

        // Brightness change on all channels, then BRIGHT=0
        reset_and_start(1, 3'b111, 4'd15, b);
        push_c("br_d15", b + 496, 15, 15, 15);
        wait_until(b + 490);
        BRIGHT = 4'd8;
        push_c("br_d12", b + 600, 12, 12, 12);
        push_i("br_busy", b + 704, 3'b000, 1'b1);
        push_i("br_done", b + 705, 3'b111, 1'b0);
        push_i("br_ph_hi", b + 728, 3'b111, 1'b0);
        push_i("br_ph_lo", b + 729, 3'b000, 1'b0);
        push_c("br_d8", b + 736, 8, 8, 8);
        wait_until(b + 740);
        BRIGHT = 4'd0;
        push_i("br0_busy", b + 741, 3'b111, 1'b1);
        push_c("br0_d7", b + 800, 7, 7, 7);
        wait_until(b + 810);

        // Reset mid-fade at duty 5
        reset_and_start(1, 3'b100, 4'd15, b);
        push_c("mr_d4", b + 144, 4, 0, 0);
        wait_until(b + 170);
        RST = 1'b1;
        push_i("mr_rst", b + 171, 3'b000, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        b2  = cyc;
        push_i("mr_busy", b2 + 1, 3'b000, 1'b1);
        push_c("mr_d0", b2 + 16, 0, 0, 0);
        push_i("mr_ph_hi", b2 + 33, 3'b100, 1'b1);
        push_i("mr_ph_lo", b2 + 34, 3'b000, 1'b1);
        push_c("mr_d1", b2 + 48, 1, 0, 0);
        wait_until(b2 + 60);

        repeat (3) @(negedge CLK);
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
